// File: rtl/status_uart_tx.sv
// Status uplink: sends a 7-byte 8N1 frame (A5, S, target[31:0], CHK) whenever the driver status/target changes.
// Optional STATUS_TX_HEARTBEAT_EN adds a periodic frame even when nothing changes.
module status_uart_tx #(
   parameter int CLK_HZ        = 100_000_000,
   parameter int BAUD          = 115_200,
   parameter int HEARTBEAT_CYC = 100_000_000
) (
   input  logic        CLK,
   input  logic        CPU_RESETN,
   input  logic        status_paused,
   input  logic        status_running,
   input  logic        status_warming,
   input  logic        status_found,
   input  logic        status_done,
   input  logic [31:0] target,
   output logic        UART_TXD,
   output logic        tx_busy,
   output logic [15:0] frame_cnt
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;
   localparam logic [2:0] LAST_BYTE = 3'd6;

   if (CLKS_PER_BIT < 4 || HEARTBEAT_CYC < 2) begin : g_bad_cfg
      $error("status_uart_tx: CLKS_PER_BIT must be >= 4 and HEARTBEAT_CYC >= 2");
   end

   function automatic logic [7:0] calc_chk(input logic [7:0] s, input logic [31:0] t);
      calc_chk = s ^ t[31:24] ^ t[23:16] ^ t[15:8] ^ t[7:0];
   endfunction

   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] s,
                                             input logic [31:0] t, input logic [7:0] chk);
      case (idx)
         3'd0:    frame_byte = 8'hA5;
         3'd1:    frame_byte = s;
         3'd2:    frame_byte = t[31:24];
         3'd3:    frame_byte = t[23:16];
         3'd4:    frame_byte = t[15:8];
         3'd5:    frame_byte = t[7:0];
         3'd6:    frame_byte = chk;
         default: frame_byte = 8'hFF;
      endcase
   endfunction

   logic [7:0]       snap_s;
   logic [36:0]      live_s;
   logic             change_s;
   logic             start_s;
   logic             hb_tick_s;
   logic             bit_end_s;
   logic [7:0]       cur_byte_s;

   logic [36:0]      last_r;
   logic             pending_r;
   logic [1:0]       state_r;
   logic [CNT_W-1:0] bit_cnt_r;
   logic [2:0]       bit_idx_r;
   logic [2:0]       byte_idx_r;
   logic [7:0]       s_buf_r;
   logic [31:0]      t_buf_r;
   logic [7:0]       chk_r;
   logic             txd_r;
   logic             busy_r;
   logic [15:0]      frame_cnt_r;

   assign snap_s     = {3'b000, status_paused, status_running, status_warming, status_found, status_done};
   assign live_s     = {snap_s[4:0], target};
   assign change_s   = (live_s != last_r);
   assign start_s    = (state_r == ST_IDLE) && (pending_r || hb_tick_s);
   assign bit_end_s  = (bit_cnt_r == BIT_LAST);
   assign cur_byte_s = frame_byte(byte_idx_r, s_buf_r, t_buf_r, chk_r);

`ifdef STATUS_TX_HEARTBEAT_EN
   localparam int HB_W = $clog2(HEARTBEAT_CYC);
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYC - 1);
   localparam logic [HB_W-1:0] HB_ONE  = HB_W'(1);
   logic [HB_W-1:0] hb_cnt_r;

   assign hb_tick_s = (hb_cnt_r == HB_LAST);

   // Heartbeat period counter, re-phased to every frame start
   always_ff @(posedge CLK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         hb_cnt_r <= '0;
      end else if (start_s || hb_tick_s) begin
         hb_cnt_r <= '0;
      end else begin
         hb_cnt_r <= hb_cnt_r + HB_ONE;
      end
   end
`else
   assign hb_tick_s = 1'b0;
`endif

   // Change detection copy and the coalescing pending flag
   always_ff @(posedge CLK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         last_r    <= 37'd0;
         pending_r <= 1'b1;
      end else begin
         last_r <= live_s;
         // The frame latches the live value, so a same-cycle change is already covered.
         if (start_s) begin
            pending_r <= 1'b0;
         end else if (change_s || hb_tick_s) begin
            pending_r <= 1'b1;
         end
      end
   end

   // Serialiser FSM: start bit, 8 data bits LSB first, stop bit, 7 bytes back-to-back
   always_ff @(posedge CLK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= CNT_ZERO;
         bit_idx_r   <= 3'd0;
         byte_idx_r  <= 3'd0;
         s_buf_r     <= 8'd0;
         t_buf_r     <= 32'd0;
         chk_r       <= 8'd0;
         txd_r       <= 1'b1;
         busy_r      <= 1'b0;
         frame_cnt_r <= 16'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               txd_r <= 1'b1;
               if (start_s) begin
                  state_r    <= ST_START;
                  bit_cnt_r  <= CNT_ZERO;
                  byte_idx_r <= 3'd0;
                  s_buf_r    <= snap_s;
                  t_buf_r    <= target;
                  chk_r      <= calc_chk(snap_s, target);
                  txd_r      <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_end_s) begin
                  state_r   <= ST_DATA;
                  bit_cnt_r <= CNT_ZERO;
                  bit_idx_r <= 3'd0;
                  txd_r     <= cur_byte_s[0];
               end else begin
                  bit_cnt_r <= bit_cnt_r + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (bit_end_s) begin
                  bit_cnt_r <= CNT_ZERO;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= ST_STOP;
                     txd_r   <= 1'b1;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     txd_r     <= cur_byte_s[bit_idx_r + 3'd1];
                  end
               end else begin
                  bit_cnt_r <= bit_cnt_r + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (bit_end_s) begin
                  bit_cnt_r <= CNT_ZERO;
                  if (byte_idx_r == LAST_BYTE) begin
                     state_r     <= ST_IDLE;
                     busy_r      <= 1'b0;
                     frame_cnt_r <= frame_cnt_r + 16'd1;
                  end else begin
                     state_r    <= ST_START;
                     byte_idx_r <= byte_idx_r + 3'd1;
                     txd_r      <= 1'b0;
                  end
               end else begin
                  bit_cnt_r <= bit_cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               txd_r   <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign UART_TXD  = txd_r;
   assign tx_busy   = busy_r;
   assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_status_uart_tx.sv
// Directed bench for status_uart_tx at 10 clocks per bit (700 clocks per frame).
module tb_status_uart_tx;

   logic        CLK;
   logic        CPU_RESETN;
   logic        status_paused;
   logic        status_running;
   logic        status_warming;
   logic        status_found;
   logic        status_done;
   logic [31:0] target;
   logic        UART_TXD;
   logic        tx_busy;
   logic [15:0] frame_cnt;

   int n_vec;
   int n_err;

   status_uart_tx #(
      .CLK_HZ       (1_000_000),
      .BAUD         (100_000),
      .HEARTBEAT_CYC(2000)
   ) dut (
      .CLK           (CLK),
      .CPU_RESETN    (CPU_RESETN),
      .status_paused (status_paused),
      .status_running(status_running),
      .status_warming(status_warming),
      .status_found  (status_found),
      .status_done   (status_done),
      .target        (target),
      .UART_TXD      (UART_TXD),
      .tx_busy       (tx_busy),
      .frame_cnt     (frame_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic wait_busy(input string tag, input int budget);
      int k;
      k = 0;
      while (tx_busy !== 1'b1 && k < budget) begin
         @(negedge CLK);
         k++;
      end
      check_val(tag, {31'd0, tx_busy}, 32'd1);
   endtask

   // Called on the first negedge with tx_busy high; returns on the negedge 700 cycles later.
   task automatic rx_frame(input string tag, input logic [55:0] exp);
      logic [7:0] rx [0:6];
      logic [7:0] eb;
      logic       e;
      int         n, b, p, line_err, busy_err;
      line_err = 0;
      busy_err = 0;
      for (int i = 0; i < 7; i++) rx[i] = 8'h00;
      for (int c = 0; c < 700; c++) begin
         n  = c / 10;
         b  = n / 10;
         p  = n % 10;
         eb = exp[55 - 8*b -: 8];
         if (p == 0) e = 1'b0;
         else if (p == 9) e = 1'b1;
         else e = eb[p-1];
         if (UART_TXD !== e) line_err++;
         if (tx_busy !== 1'b1) busy_err++;
         if ((c % 10) == 5 && p >= 1 && p <= 8) rx[b][p-1] = UART_TXD;
         @(negedge CLK);
      end
      for (int i = 0; i < 7; i++)
         check_val($sformatf("%s_byte%0d", tag, i), {24'd0, rx[i]}, {24'd0, exp[55 - 8*i -: 8]});
      check_val({tag, "_bit_timing"}, line_err, 32'd0);
      check_val({tag, "_busy_span"}, busy_err, 32'd0);
      check_val({tag, "_busy_end"}, {31'd0, tx_busy}, 32'd0);
      check_val({tag, "_idle_line"}, {31'd0, UART_TXD}, 32'd1);
   endtask

   initial begin
      int busy_seen;
      n_vec = 0;
      n_err = 0;
      CPU_RESETN     = 1'b0;
      status_paused  = 1'b0;
      status_running = 1'b0;
      status_warming = 1'b0;
      status_found   = 1'b0;
      status_done    = 1'b0;
      target         = 32'h0000_0000;
      repeat (3) @(negedge CLK);
      check_val("rst_txd", {31'd0, UART_TXD}, 32'd1);
      check_val("rst_busy", {31'd0, tx_busy}, 32'd0);
      check_val("rst_cnt", {16'd0, frame_cnt}, 32'd0);

      // Power-up frame with all-zero snapshot
      CPU_RESETN = 1'b1;
      wait_busy("f1_start", 10);
      rx_frame("f1", 56'hA5_00_00000000_00);
      check_val("f1_cnt", {16'd0, frame_cnt}, 32'd1);

      busy_seen = 0;
      repeat (20) begin
         @(negedge CLK);
         if (tx_busy) busy_seen++;
      end
      check_val("quiet_after_f1", busy_seen, 32'd0);

      // running=1 -> S=0x08; checksum 08^12^34^56^78 = 0x00
      status_running = 1'b1;
      target         = 32'h1234_5678;
      wait_busy("f2_start", 10);
      fork
         rx_frame("f2", 56'hA5_08_12345678_00);
         begin
            repeat (100) @(negedge CLK);
            status_found = 1'b1;
            repeat (100) @(negedge CLK);
            status_found = 1'b0;
            repeat (100) @(negedge CLK);
            status_found = 1'b1;
            repeat (100) @(negedge CLK);
            target = 32'hDEAD_BEEF;
         end
      join
      @(negedge CLK);
      check_val("b2b_start", {31'd0, tx_busy}, 32'd1);
      // S=0x0A; checksum 0A^DE^AD^BE^EF = 0x28
      rx_frame("f3", 56'hA5_0A_DEADBEEF_28);
      check_val("f3_cnt", {16'd0, frame_cnt}, 32'd3);

      busy_seen = 0;
      repeat (50) begin
         @(negedge CLK);
         if (tx_busy) busy_seen++;
      end
      check_val("no_third_extra", busy_seen, 32'd0);

      // Reset 300 cycles into a frame
      target = 32'h0000_00FF;
      wait_busy("f4_start", 10);
      repeat (300) @(negedge CLK);
      #1 CPU_RESETN = 1'b0;
      #1;
      check_val("async_rst_txd", {31'd0, UART_TXD}, 32'd1);
      check_val("async_rst_busy", {31'd0, tx_busy}, 32'd0);
      check_val("async_rst_cnt", {16'd0, frame_cnt}, 32'd0);
      repeat (3) @(negedge CLK);
      CPU_RESETN = 1'b1;
      wait_busy("f5_start", 10);
      // checksum 0A^00^00^00^FF = 0xF5
      rx_frame("f5", 56'hA5_0A_000000FF_F5);
      check_val("f5_cnt", {16'd0, frame_cnt}, 32'd1);

      busy_seen = 0;
      repeat (10_000) begin
         @(negedge CLK);
         if (tx_busy) busy_seen++;
      end
      check_val("hold_no_frames", busy_seen, 32'd0);
      check_val("hold_cnt", {16'd0, frame_cnt}, 32'd1);

      // Counter wrap
      force dut.frame_cnt_r = 16'hFFFF;
      @(negedge CLK);
      release dut.frame_cnt_r;
      @(negedge CLK);
      check_val("preload_cnt", {16'd0, frame_cnt}, 32'h0000_FFFF);
      target = 32'h0000_0001;
      wait_busy("f6_start", 10);
      rx_frame("f6", 56'hA5_0A_00000001_0B);
      check_val("wrap_cnt0", {16'd0, frame_cnt}, 32'h0000_0000);
      target = 32'h0000_0002;
      wait_busy("f7_start", 10);
      rx_frame("f7", 56'hA5_0A_00000002_08);
      check_val("wrap_cnt1", {16'd0, frame_cnt}, 32'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
